// File: rtl/flash_phy_prog_timer.sv
// flash_phy_prog_timer
// Sequences the flash macro program pulse (setup -> pulse -> recover) for one
// packed word per request. It acknowledges the word when it is accepted and
// strobes done when the last word of a burst has finished.
// Optional build macro FLASH_PROG_VERIFY_EN adds a one-cycle read-back verify
// state after recovery and drives a sticky err_o on any under-programmed bit.
module flash_phy_prog_timer #(
   parameter int DataW         = 76,
   parameter int AddrW         = 9,
   parameter int CntW          = 8,
   parameter int SetupCycles   = 4,
   parameter int PulseCycles   = 32,
   parameter int RecoverCycles = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_i,
   input  logic             last_i,
   input  logic [AddrW-1:0] addr_i,
   input  logic [DataW-1:0] data_i,
   output logic             ack_o,
   output logic             done_o,
   output logic             prog_en_o,
   output logic             pulse_o,
   output logic [AddrW-1:0] addr_o,
   output logic [DataW-1:0] data_o,
   input  logic [DataW-1:0] rd_data_i,
   output logic             err_o
);

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StSetup   = 3'd1,
      StPulse   = 3'd2,
      StRecover = 3'd3,
`ifdef FLASH_PROG_VERIFY_EN
      StVerify  = 3'd4,
`endif
      StDone    = 3'd5
   } state_e;

   // A state ends on the cycle its counter reaches N-1, so it lasts N cycles.
   localparam logic [CntW-1:0] SetupLast   = CntW'(SetupCycles - 1);
   localparam logic [CntW-1:0] PulseLast   = CntW'(PulseCycles - 1);
   localparam logic [CntW-1:0] RecoverLast = CntW'(RecoverCycles - 1);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              last_q;
   logic              latch;
   logic [AddrW-1:0]  addr_q;
   logic [DataW-1:0]  data_q;

   // State, counter and latched word registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (latch) begin
            last_q <= last_i;
            addr_q <= addr_i;
            data_q <= data_i;
         end
      end
   end

   // Next-state and output decode; the counter restarts on every state change
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + 1'b1;
      ack_o     = 1'b0;
      done_o    = 1'b0;
      prog_en_o = 1'b0;
      pulse_o   = 1'b0;
      latch     = 1'b0;
      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (req_i) begin
               ack_o = 1'b1;
               latch = 1'b1;
               if (&data_i) begin
                  if (last_i) state_d = StDone;
               end else begin
                  state_d = StSetup;
               end
            end
         end
         StSetup: begin
            prog_en_o = 1'b1;
            if (cnt_q == SetupLast) state_d = StPulse;
         end
         StPulse: begin
            prog_en_o = 1'b1;
            pulse_o   = 1'b1;
            if (cnt_q == PulseLast) state_d = StRecover;
         end
         StRecover: begin
            prog_en_o = 1'b1;
            if (cnt_q == RecoverLast) begin
`ifdef FLASH_PROG_VERIFY_EN
               state_d = StVerify;
`else
               state_d = last_q ? StDone : StIdle;
`endif
            end
         end
`ifdef FLASH_PROG_VERIFY_EN
         StVerify: begin
            state_d = last_q ? StDone : StIdle;
         end
`endif
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   assign addr_o = addr_q;
   assign data_o = data_q;

`ifdef FLASH_PROG_VERIFY_EN
   logic err_q;

   // A bit meant to be programmed (0) that reads back erased (1) flags a sticky error
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         err_q <= 1'b0;
      end else if ((state_q == StVerify) && (|(~data_q & rd_data_i))) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   logic unused_rd;

   assign unused_rd = ^rd_data_i;
   assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_flash_phy_prog_timer.sv
// Directed testbench for flash_phy_prog_timer. Each scenario task drives a
// request, records a per-cycle trace of the outputs (cycle 0 = acceptance
// cycle) and compares it against hand-computed timing.
module tb_flash_phy_prog_timer;

   localparam int DataW = 76;
   localparam int AddrW = 9;
`ifdef FLASH_PROG_VERIFY_EN
   localparam int VerX = 1;
`else
   localparam int VerX = 0;
`endif
   // Cycles from acceptance until the FSM is back in idle for a non-last word
   localparam int WordC = 45 + VerX;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             req_i;
   logic             last_i;
   logic [AddrW-1:0] addr_i;
   logic [DataW-1:0] data_i;
   logic [DataW-1:0] rd_data_i;
   logic             ack_o, done_o, prog_en_o, pulse_o, err_o;
   logic [AddrW-1:0] addr_o;
   logic [DataW-1:0] data_o;

   int pass_cnt  = 0;
   int check_cnt = 0;

   logic             ack_tr   [0:127];
   logic             done_tr  [0:127];
   logic             prog_tr  [0:127];
   logic             pulse_tr [0:127];
   logic             err_tr   [0:127];
   logic [AddrW-1:0] addr_tr  [0:127];
   logic [DataW-1:0] data_tr  [0:127];

   int ack_n, done_n, prog_n, pulse_n;
   int done_at, pulse_first, pulse_last, prog_first, prog_last;

   flash_phy_prog_timer dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .last_i    (last_i),
      .addr_i    (addr_i),
      .data_i    (data_i),
      .ack_o     (ack_o),
      .done_o    (done_o),
      .prog_en_o (prog_en_o),
      .pulse_o   (pulse_o),
      .addr_o    (addr_o),
      .data_o    (data_o),
      .rd_data_i (rd_data_i),
      .err_o     (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Record n cycles of outputs at each negedge; inputs change 1 time unit after posedge.
   // Optionally swaps in a second word after cycle 0, and drops req after cycle drop_at.
   task automatic trace(input int n, input bit sw, input logic [AddrW-1:0] na,
                        input logic [DataW-1:0] nd, input logic nl, input int drop_at);
      for (int c = 0; c < n; c++) begin
         @(negedge clk_i);
         ack_tr[c]   = ack_o;
         done_tr[c]  = done_o;
         prog_tr[c]  = prog_en_o;
         pulse_tr[c] = pulse_o;
         err_tr[c]   = err_o;
         addr_tr[c]  = addr_o;
         data_tr[c]  = data_o;
         @(posedge clk_i);
         #1;
         if (sw && c == 0) begin
            addr_i = na;
            data_i = nd;
            last_i = nl;
         end
         if (c == drop_at) req_i = 1'b0;
      end
   endtask

   task automatic summarize(input int n);
      ack_n = 0; done_n = 0; prog_n = 0; pulse_n = 0;
      done_at = -1; pulse_first = -1; pulse_last = -1; prog_first = -1; prog_last = -1;
      for (int c = 0; c < n; c++) begin
         if (ack_tr[c] === 1'b1) ack_n++;
         if (done_tr[c] === 1'b1) begin done_n++; done_at = c; end
         if (prog_tr[c] === 1'b1) begin
            prog_n++;
            if (prog_first < 0) prog_first = c;
            prog_last = c;
         end
         if (pulse_tr[c] === 1'b1) begin
            pulse_n++;
            if (pulse_first < 0) pulse_first = c;
            pulse_last = c;
         end
      end
   endtask

   task automatic start_req(input logic [AddrW-1:0] a, input logic [DataW-1:0] d, input logic l);
      addr_i = a;
      data_i = d;
      last_i = l;
      req_i  = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0; req_i = 1'b0; last_i = 1'b0;
      addr_i = '0; data_i = '0; rd_data_i = '0;
      repeat (3) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check_cnt++; if (ack_o !== 1'b0) $display("[TB] FAIL reset_ack got %b want 0", ack_o); else pass_cnt++;
      check_cnt++; if (done_o !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", done_o); else pass_cnt++;
      check_cnt++; if (prog_en_o !== 1'b0) $display("[TB] FAIL reset_prog_en got %b want 0", prog_en_o); else pass_cnt++;
      check_cnt++; if (pulse_o !== 1'b0) $display("[TB] FAIL reset_pulse got %b want 0", pulse_o); else pass_cnt++;
      check_cnt++; if (err_o !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", err_o); else pass_cnt++;
      check_cnt++; if (addr_o !== '0) $display("[TB] FAIL reset_addr got %h want 0", addr_o); else pass_cnt++;
      check_cnt++; if (data_o !== '0) $display("[TB] FAIL reset_data got %h want 0", data_o); else pass_cnt++;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   task automatic test_single();
      start_req(9'h012, '0, 1'b1);
      trace(60, 1'b0, '0, '0, 1'b0, 0);
      summarize(60);
      check_cnt++; if (ack_tr[0] !== 1'b1) $display("[TB] FAIL single_ack_c0 got %b want 1", ack_tr[0]); else pass_cnt++;
      check_cnt++; if (ack_n !== 1) $display("[TB] FAIL single_ack_count got %0d want 1", ack_n); else pass_cnt++;
      check_cnt++; if (pulse_first !== 5) $display("[TB] FAIL single_pulse_first got %0d want 5", pulse_first); else pass_cnt++;
      check_cnt++; if (pulse_last !== 36) $display("[TB] FAIL single_pulse_last got %0d want 36", pulse_last); else pass_cnt++;
      check_cnt++; if (prog_first !== 1) $display("[TB] FAIL single_prog_first got %0d want 1", prog_first); else pass_cnt++;
      check_cnt++; if (prog_last !== 44) $display("[TB] FAIL single_prog_last got %0d want 44", prog_last); else pass_cnt++;
      check_cnt++; if (done_n !== 1) $display("[TB] FAIL single_done_count got %0d want 1", done_n); else pass_cnt++;
      check_cnt++; if (done_at !== WordC) $display("[TB] FAIL single_done_cycle got %0d want %0d", done_at, WordC); else pass_cnt++;
      check_cnt++; if (addr_tr[10] !== 9'h012) $display("[TB] FAIL single_addr got %h want 012", addr_tr[10]); else pass_cnt++;
      check_cnt++; if (data_tr[10] !== '0) $display("[TB] FAIL single_data got %h want 0", data_tr[10]); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [DataW-1:0] wa, wb;
      wa = {19{4'h3}};
      wb = {19{4'hC}};
      // req stays high with the second word presented during the first word's sequence
      start_req(9'h0A5, wa, 1'b0);
      trace(110, 1'b1, 9'h1C3, wb, 1'b1, WordC);
      summarize(110);
      check_cnt++; if (ack_n !== 2) $display("[TB] FAIL b2b_ack_count got %0d want 2", ack_n); else pass_cnt++;
      check_cnt++; if (ack_tr[WordC] !== 1'b1) $display("[TB] FAIL b2b_ack2_cycle got %b want 1", ack_tr[WordC]); else pass_cnt++;
      check_cnt++; if (done_n !== 1) $display("[TB] FAIL b2b_done_count got %0d want 1", done_n); else pass_cnt++;
      check_cnt++; if (done_at !== 2 * WordC) $display("[TB] FAIL b2b_done_cycle got %0d want %0d", done_at, 2 * WordC); else pass_cnt++;
      check_cnt++; if (prog_tr[WordC] !== 1'b0) $display("[TB] FAIL b2b_prog_gap got %b want 0", prog_tr[WordC]); else pass_cnt++;
      check_cnt++; if (pulse_n !== 64) $display("[TB] FAIL b2b_pulse_count got %0d want 64", pulse_n); else pass_cnt++;
      check_cnt++; if (addr_tr[20] !== 9'h0A5) $display("[TB] FAIL busy_addr_stable got %h want 0a5", addr_tr[20]); else pass_cnt++;
      check_cnt++; if (data_tr[20] !== wa) $display("[TB] FAIL busy_data_stable got %h want %h", data_tr[20], wa); else pass_cnt++;
      check_cnt++; if (addr_tr[WordC + 10] !== 9'h1C3) $display("[TB] FAIL b2b_addr2 got %h want 1c3", addr_tr[WordC + 10]); else pass_cnt++;
      check_cnt++; if (data_tr[WordC + 10] !== wb) $display("[TB] FAIL b2b_data2 got %h want %h", data_tr[WordC + 10], wb); else pass_cnt++;
   endtask

   task automatic test_all_ones();
      start_req(9'h033, '1, 1'b1);
      trace(6, 1'b0, '0, '0, 1'b0, 0);
      summarize(6);
      check_cnt++; if (ack_tr[0] !== 1'b1) $display("[TB] FAIL ones_ack got %b want 1", ack_tr[0]); else pass_cnt++;
      check_cnt++; if (done_tr[1] !== 1'b1) $display("[TB] FAIL ones_done_c1 got %b want 1", done_tr[1]); else pass_cnt++;
      check_cnt++; if (done_n !== 1) $display("[TB] FAIL ones_done_count got %0d want 1", done_n); else pass_cnt++;
      check_cnt++; if (prog_n !== 0) $display("[TB] FAIL ones_prog_count got %0d want 0", prog_n); else pass_cnt++;
      check_cnt++; if (pulse_n !== 0) $display("[TB] FAIL ones_pulse_count got %0d want 0", pulse_n); else pass_cnt++;
      start_req(9'h034, '1, 1'b0);
      trace(6, 1'b0, '0, '0, 1'b0, 0);
      summarize(6);
      check_cnt++; if (ack_n !== 1) $display("[TB] FAIL ones_nl_ack_count got %0d want 1", ack_n); else pass_cnt++;
      check_cnt++; if (done_n !== 0) $display("[TB] FAIL ones_nl_done_count got %0d want 0", done_n); else pass_cnt++;
      check_cnt++; if (prog_n !== 0) $display("[TB] FAIL ones_nl_prog_count got %0d want 0", prog_n); else pass_cnt++;
      check_cnt++; if (addr_tr[2] !== 9'h034) $display("[TB] FAIL ones_nl_addr got %h want 034", addr_tr[2]); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      start_req(9'h077, '0, 1'b1);
      trace(11, 1'b0, '0, '0, 1'b0, 0);
      check_cnt++; if (pulse_tr[10] !== 1'b1) $display("[TB] FAIL mid_in_pulse got %b want 1", pulse_tr[10]); else pass_cnt++;
      rst_ni = 1'b0;
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      trace(50, 1'b0, '0, '0, 1'b0, 0);
      summarize(50);
      check_cnt++; if (prog_tr[0] !== 1'b0) $display("[TB] FAIL mid_prog_after got %b want 0", prog_tr[0]); else pass_cnt++;
      check_cnt++; if (pulse_tr[0] !== 1'b0) $display("[TB] FAIL mid_pulse_after got %b want 0", pulse_tr[0]); else pass_cnt++;
      check_cnt++; if (addr_tr[0] !== '0) $display("[TB] FAIL mid_addr_after got %h want 0", addr_tr[0]); else pass_cnt++;
      check_cnt++; if (data_tr[0] !== '0) $display("[TB] FAIL mid_data_after got %h want 0", data_tr[0]); else pass_cnt++;
      check_cnt++; if (prog_n !== 0) $display("[TB] FAIL mid_prog_count got %0d want 0", prog_n); else pass_cnt++;
      check_cnt++; if (done_n !== 0) $display("[TB] FAIL mid_no_done got %0d want 0", done_n); else pass_cnt++;
      start_req(9'h040, {19{4'h1}}, 1'b1);
      trace(60, 1'b0, '0, '0, 1'b0, 0);
      summarize(60);
      check_cnt++; if (pulse_first !== 5) $display("[TB] FAIL fresh_pulse_first got %0d want 5", pulse_first); else pass_cnt++;
      check_cnt++; if (done_n !== 1) $display("[TB] FAIL fresh_done_count got %0d want 1", done_n); else pass_cnt++;
      check_cnt++; if (done_at !== WordC) $display("[TB] FAIL fresh_done_cycle got %0d want %0d", done_at, WordC); else pass_cnt++;
   endtask

`ifdef FLASH_PROG_VERIFY_EN
   task automatic test_verify();
      // Read-back matching the word: no error
      rd_data_i = {19{4'h3}};
      start_req(9'h050, {19{4'h3}}, 1'b1);
      trace(60, 1'b0, '0, '0, 1'b0, 0);
      check_cnt++; if (err_tr[59] !== 1'b0) $display("[TB] FAIL verify_clean_err got %b want 0", err_tr[59]); else pass_cnt++;
      // Bit 3 fails to program
      rd_data_i = 76'h8;
      start_req(9'h051, '0, 1'b1);
      trace(60, 1'b0, '0, '0, 1'b0, 0);
      summarize(60);
      check_cnt++; if (err_tr[WordC - 1] !== 1'b0) $display("[TB] FAIL verify_err_early got %b want 0", err_tr[WordC - 1]); else pass_cnt++;
      check_cnt++; if (err_tr[WordC] !== 1'b1) $display("[TB] FAIL verify_err_set got %b want 1", err_tr[WordC]); else pass_cnt++;
      check_cnt++; if (done_at !== WordC) $display("[TB] FAIL verify_done_cycle got %0d want %0d", done_at, WordC); else pass_cnt++;
      // Error is sticky and does not block the next word
      rd_data_i = '0;
      start_req(9'h052, {19{4'h3}}, 1'b1);
      trace(60, 1'b0, '0, '0, 1'b0, 0);
      summarize(60);
      check_cnt++; if (err_tr[59] !== 1'b1) $display("[TB] FAIL verify_err_sticky got %b want 1", err_tr[59]); else pass_cnt++;
      check_cnt++; if (done_n !== 1) $display("[TB] FAIL verify_next_done got %0d want 1", done_n); else pass_cnt++;
   endtask
`else
   task automatic test_err_tied();
      rd_data_i = '1;
      start_req(9'h051, '0, 1'b1);
      trace(60, 1'b0, '0, '0, 1'b0, 0);
      summarize(60);
      check_cnt++; if (err_tr[59] !== 1'b0) $display("[TB] FAIL err_tied got %b want 0", err_tr[59]); else pass_cnt++;
      check_cnt++; if (done_at !== WordC) $display("[TB] FAIL err_tied_done_cycle got %0d want %0d", done_at, WordC); else pass_cnt++;
      rd_data_i = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_all_ones();
      test_reset_mid();
`ifdef FLASH_PROG_VERIFY_EN
      test_verify();
`else
      test_err_tied();
`endif
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
